// File: rtl/led_phase_sequencer.sv
// led_phase_sequencer
//   N-phase colour sequencer for an active-low RGB LED, driven by two
//   active-low push buttons. Each button is synchronised, debounced and
//   edge-detected into a one-cycle press pulse. A small IDLE/RUN/HOLD FSM
//   then steps through a packed colour table, spending PHASE_CYCLES clocks
//   in each phase.
//
//   Optional feature macro: LED_PWM_EN. When it is defined, the lit LED
//   bits are dimmed by an 8-bit free-running PWM frame. Each 256-cycle
//   frame keeps the bits lit for PWM_DUTY cycles.
//
// Ports
//   clk       in   1             single clock, posedge only
//   rst       in   1             synchronous active-high reset
//   button_0  in   1             STOP button, active-low, asynchronous
//   button_1  in   1             START button, active-low, asynchronous
//   led       out  LED_W         registered colour, active-low (0 = lit)
//   phase     out  clog2(N)      current phase index
//   running   out  1             1 while in RUN
module led_phase_sequencer #(
  parameter int                        LED_W           = 3,
  parameter int                        N_PHASES        = 3,
  parameter logic [LED_W*N_PHASES-1:0] COLOURS         = 9'b101_011_110,
  parameter int                        PHASE_CYCLES    = 30_000_000,
  parameter int                        DEBOUNCE_CYCLES = 270_000,
  parameter int                        PWM_DUTY        = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        button_0,
  input  logic                        button_1,
  output logic [LED_W-1:0]            led,
  output logic [$clog2(N_PHASES)-1:0] phase,
  output logic                        running
);

  localparam int PH_W  = $clog2(N_PHASES);
  localparam int CNT_W = $clog2(PHASE_CYCLES);
  localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_HOLD = 2'b10
  } state_t;

  // Index 0 is the STOP button and index 1 is the START button.
  logic [1:0]            sync_a_q,  sync_a_d;
  logic [1:0]            sync_b_q,  sync_b_d;
  logic [1:0]            db_lvl_q,  db_lvl_d;
  logic [1:0]            db_prev_q, db_prev_d;
  logic [1:0]            press_q,   press_d;
  logic [1:0][DB_W-1:0]  db_cnt_q,  db_cnt_d;

  state_t                state_q,   state_d;
  logic [CNT_W-1:0]      cnt_q,     cnt_d;
  logic [PH_W-1:0]       phase_q,   phase_d;
  logic [LED_W-1:0]      led_q,     led_d;
  logic                  running_q, running_d;

  logic                  stop_p;
  logic                  start_p;

  // Table lookup that stays in range for any phase code, including unused ones.
  function automatic logic [LED_W-1:0] colour_of(input logic [PH_W-1:0] p);
    logic [LED_W-1:0] c;
    c = '1;
    for (int i = 0; i < N_PHASES; i++) begin
      if (p == PH_W'(i)) begin
        c = COLOURS[i*LED_W +: LED_W];
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  // Button path: 2-flop synchroniser, stability counter and falling-edge pulse.
  always_comb begin
    sync_a_d  = {button_1, button_0};
    sync_b_d  = sync_a_q;
    db_lvl_d  = db_lvl_q;
    db_cnt_d  = db_cnt_q;
    for (int b = 0; b < 2; b++) begin
      if (sync_b_q[b] == db_lvl_q[b]) begin
        db_cnt_d[b] = '0;
      end else if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        // The new level has disagreed for DEBOUNCE_CYCLES samples in a row.
        db_cnt_d[b] = '0;
        db_lvl_d[b] = sync_b_q[b];
      end else begin
        db_cnt_d[b] = db_cnt_q[b] + DB_W'(1);
      end
    end
    db_prev_d = db_lvl_q;
    // The press pulse is registered, so it arrives one cycle after the level falls.
    press_d   = db_prev_q & ~db_lvl_q;
  end

  assign stop_p  = press_q[0];
  assign start_p = press_q[1];

`ifdef LED_PWM_EN
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic       pwm_off_s;

  // Free-running PWM frame counter; 9-bit compare keeps PWM_DUTY=256 meaningful.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
    pwm_off_s = ({1'b0, pwm_cnt_q} >= 9'(PWM_DUTY));
  end

  // PWM frame counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  logic pwm_off_s;

  // Without PWM the LED is always at full brightness.
  always_comb begin
    pwm_off_s = 1'b0;
  end
`endif

  // FSM next state, phase counting and output values.
  // Outputs are computed from the next state, so they change on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    case (state_q)
      S_IDLE: begin
        if (stop_p) begin
          // Stop has priority, and stop does nothing in IDLE.
          state_d = S_IDLE;
        end else if (start_p) begin
          state_d = S_RUN;
          cnt_d   = '0;
          phase_d = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop_p) begin
          state_d = S_HOLD;
        end else if (start_p) begin
          cnt_d   = '0;
          phase_d = '0;
        end else if (cnt_q == CNT_W'(PHASE_CYCLES - 1)) begin
          cnt_d = '0;
          if (phase_q == PH_W'(N_PHASES - 1)) begin
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (stop_p) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          phase_d = '0;
        end else if (start_p) begin
          // Resume from the frozen cnt and phase; counting continues on the next edge.
          state_d = S_RUN;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        phase_d = '0;
      end
    endcase

    running_d = (state_d == S_RUN);
    if (state_d == S_IDLE) begin
      led_d = '1;
    end else begin
      // Forcing every bit high turns off the lit bits; the unlit bits are already 1.
      led_d = colour_of(phase_d) | {LED_W{pwm_off_s}};
    end
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a_q  <= 2'b11;
      sync_b_q  <= 2'b11;
      db_lvl_q  <= 2'b11;
      db_prev_q <= 2'b11;
      press_q   <= 2'b00;
      db_cnt_q  <= '0;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      phase_q   <= '0;
      led_q     <= '1;
      running_q <= 1'b0;
    end else begin
      sync_a_q  <= sync_a_d;
      sync_b_q  <= sync_b_d;
      db_lvl_q  <= db_lvl_d;
      db_prev_q <= db_prev_d;
      press_q   <= press_d;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      led_q     <= led_d;
      running_q <= running_d;
    end
  end

  assign led     = led_q;
  assign phase   = phase_q;
  assign running = running_q;

endmodule

// File: tb/tb_led_phase_sequencer.sv
// Testbench for led_phase_sequencer (PHASE_CYCLES=4, DEBOUNCE_CYCLES=2).
//
// A reference model runs on every clock edge and pushes the expected
// {led, phase, running} values into a queue. A monitor on the falling edge
// pops each entry and compares it with the DUT outputs.
//
// The reference model works in terms of:
//   - accepted button levels: a level flips once the last D synchronised
//     samples all disagree with it;
//   - elapsed run time: the phase is (elapsed / PHASE_CYCLES) mod N.
module tb_led_phase_sequencer;

  localparam int LED_W    = 3;
  localparam int N_PHASES = 3;
  localparam int PC       = 4;
  localparam int DB       = 2;
  localparam int PWM_DUTY = 64;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  typedef struct packed {
    logic [2:0] led;
    logic [1:0] phase;
    logic       running;
  } obs_t;

  bit         clk = 1'b0;
  logic       rst;
  logic       button_0;
  logic       button_1;
  logic [2:0] led;
  logic [1:0] phase;
  logic       running;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  led_phase_sequencer #(
    .LED_W          (LED_W),
    .N_PHASES       (N_PHASES),
    .COLOURS        (9'b101_011_110),
    .PHASE_CYCLES   (PC),
    .DEBOUNCE_CYCLES(DB),
    .PWM_DUTY       (PWM_DUTY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .button_0(button_0),
    .button_1(button_1),
    .led     (led),
    .phase   (phase),
    .running (running)
  );

  // Reference model state.
  bit          model_on = 1'b0;
  int          mode;
  int          elapsed;
  bit          lvl   [2];
  bit          fell  [2];
  bit          pulse [2];
  bit [DB+1:0] sh    [2];   // bit 0 holds the newest raw sample
  logic [2:0]  colour_tab [3];
`ifdef LED_PWM_EN
  int          pwm_m;
`endif

  initial begin
    colour_tab[0] = 3'b110;
    colour_tab[1] = 3'b011;
    colour_tab[2] = 3'b101;
  end

  // Reference model: advance one clock and predict the outputs after this edge.
  always @(posedge clk) begin
    obs_t e;
    bit   raw [2];
    bit   newfell;
    int   ph;
    int   pwm_used;
    raw[0]   = button_0;
    raw[1]   = button_1;
    pwm_used = 0;
    if (rst) begin
      model_on = 1'b1;
      mode     = M_IDLE;
      elapsed  = 0;
`ifdef LED_PWM_EN
      pwm_m    = 0;
`endif
      for (int b = 0; b < 2; b++) begin
        lvl[b]   = 1'b1;
        fell[b]  = 1'b0;
        pulse[b] = 1'b0;
        sh[b]    = '1;
      end
    end else if (model_on) begin
      if (pulse[0]) begin
        if (mode == M_RUN) begin
          mode = M_HOLD;
        end else if (mode == M_HOLD) begin
          mode    = M_IDLE;
          elapsed = 0;
        end
      end else if (pulse[1]) begin
        if (mode != M_HOLD) elapsed = 0;
        mode = M_RUN;
      end else if (mode == M_RUN) begin
        elapsed = (elapsed + 1) % (PC * N_PHASES);
      end
`ifdef LED_PWM_EN
      pwm_used = pwm_m;
      pwm_m    = (pwm_m + 1) % 256;
`endif
      for (int b = 0; b < 2; b++) begin
        sh[b]   = {sh[b][DB:0], raw[b]};
        newfell = 1'b0;
        if (lvl[b] ? (sh[b][DB+1:2] == '0) : (&sh[b][DB+1:2])) begin
          lvl[b]  = ~lvl[b];
          newfell = (lvl[b] == 1'b0);
        end
        pulse[b] = fell[b];
        fell[b]  = newfell;
      end
    end
    if (model_on) begin
      ph        = (elapsed / PC) % N_PHASES;
      e.running = (mode == M_RUN);
      e.phase   = 2'(ph);
      e.led     = (mode == M_IDLE) ? 3'b111 : colour_tab[ph];
`ifdef LED_PWM_EN
      if (mode != M_IDLE && pwm_used >= PWM_DUTY) e.led = 3'b111;
`endif
      exp_q.push_back(e);
    end
  end

  // Monitor: compare the DUT outputs with the oldest prediction, away from the active edge.
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({led, phase, running} !== e) begin
        n_bad++;
        $display("FAIL outputs @%0t: got led=%b phase=%0d running=%b, expected led=%b phase=%0d running=%b",
                 $time, led, phase, running, e.led, e.phase, e.running);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic press(input bit use0, input bit use1, input int hold, input int gap);
    if (use0) button_0 = 1'b0;
    if (use1) button_1 = 1'b0;
    tick(hold);
    button_0 = 1'b1;
    button_1 = 1'b1;
    tick(gap);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  initial begin
    int act;
    rst      = 1'b1;
    button_0 = 1'b1;
    button_1 = 1'b1;
    // Reset for 3 cycles.
    tick(3);
    rst = 1'b0;
    tick(3);
    // Hold START low: one start pulse, then at least three full phase steps and a wrap.
    press(1'b0, 1'b1, 40, 5);
    // STOP, freeze for a while, then resume.
    press(1'b1, 1'b0, 3, 25);
    press(1'b0, 1'b1, 3, 12);
    // Two STOP presses return to IDLE.
    press(1'b1, 1'b0, 3, 6);
    press(1'b1, 1'b0, 3, 10);
    // One-cycle glitches on either button must not register as presses.
    press(1'b1, 1'b0, 1, 6);
    press(1'b0, 1'b1, 1, 6);
    // Both buttons pressed together in RUN: stop wins.
    press(1'b0, 1'b1, 3, 9);
    press(1'b1, 1'b1, 3, 10);
    // Reset in the middle of RUN.
    press(1'b0, 1'b1, 3, 9);
    do_reset(1);
    tick(4);
    // Randomised button activity.
    for (int i = 0; i < 260; i++) begin
      act = $urandom_range(0, 9);
      case (act)
        0, 1, 2: press(1'b0, 1'b1, $urandom_range(1, 6), $urandom_range(1, 12));
        3, 4:    press(1'b1, 1'b0, $urandom_range(1, 6), $urandom_range(1, 25));
        5:       press(1'b1, 1'b1, $urandom_range(1, 5), $urandom_range(1, 10));
        6:       press($urandom_range(0, 1) == 0, $urandom_range(0, 1) == 1, 1, $urandom_range(1, 4));
        7, 8:    tick($urandom_range(1, 30));
        default: begin
          if ($urandom_range(0, 3) == 0) do_reset($urandom_range(1, 3));
          else tick(1);
        end
      endcase
    end
    tick(4);
    if (n_cmp < 12) begin
      n_bad++;
      $display("FAIL compare_count: got %0d comparisons, expected at least 12", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
